// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the binary-to-BCD encoder:
//   - bcd_state_e   : controller state encoding (IDLE, SHIFT, DONE)
//   - BCD_BLANK     : digit code the segment decoder renders as all-off
//   - bcd_min_digits: decimal digits needed to hold any BIN_WIDTH-bit value
//   - bcd_digits_ok : parameter legality check used by the DIGITS assertion
// -----------------------------------------------------------------------------
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } bcd_state_e;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  // ceil(w * log10(2)), using log10(2) ~= 0.30103 in fixed point. 2^w is
  // never a power of ten, so this equals the digit count of 2^w - 1.
  function automatic int bcd_min_digits(input int w);
    return (w * 30103 + 99999) / 100000;
  endfunction

  function automatic bit bcd_digits_ok(input int w, input int digits);
    return digits >= bcd_min_digits(w);
  endfunction

endpackage : bcd_pkg

// File: rtl/bcd_add3_cell.sv
// -----------------------------------------------------------------------------
// bcd_add3_cell
// Combinational double-dabble correction for one BCD digit: a digit of 5 or
// more gets +3 so the following left shift carries correctly into the next
// decimal digit. The result is kept to 4 bits (no carry out).
// Ports:
//   digit_i  in  [3:0]  scratch digit before correction
//   digit_o  out [3:0]  corrected digit
// -----------------------------------------------------------------------------
module bcd_add3_cell (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  always_comb begin
    digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;
  end

endmodule : bcd_add3_cell

// File: rtl/bin_to_bcd_encoder.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_encoder
// Sequential shift-and-add-3 (double-dabble) binary-to-BCD converter. One
// input bit is consumed per clock; a conversion takes BIN_WIDTH SHIFT cycles
// followed by a one-cycle DONE, during which a new start is accepted.
//
// Parameters:
//   BIN_WIDTH  width of the unsigned binary input (default 16)
//   DIGITS     number of BCD output digits (default 5), must be at least
//              ceil(BIN_WIDTH*log10(2))
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   conversion request, sampled in IDLE or DONE only
//   bin_in   in   [BIN_WIDTH-1:0] value, captured on the accepting edge
//   busy     out  high while shifting
//   done     out  one-cycle pulse, bcd_out freshly updated
//   bcd_out  out  [4*DIGITS-1:0] packed BCD, digit 0 in bits [3:0]
// Build option:
//   BCD_LEADING_BLANK_EN  when defined, leading zero digits above digit 0 are
//                         loaded into bcd_out as BCD_BLANK (4'hF).
// -----------------------------------------------------------------------------
module bin_to_bcd_encoder
  import bcd_pkg::*;
#(
  parameter int BIN_WIDTH = 16,
  parameter int DIGITS    = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int  CNT_W     = $clog2(BIN_WIDTH + 1);
  localparam int  SCR_W     = 4 * DIGITS;
  localparam bit  DIGITS_OK = bcd_digits_ok(BIN_WIDTH, DIGITS);

  digits_check: assert property (@(posedge clk) DIGITS_OK)
    else $fatal(1, "bin_to_bcd_encoder: DIGITS too small for BIN_WIDTH");

  bcd_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [BIN_WIDTH-1:0] bin_q;
  logic [SCR_W-1:0]     scratch_q;
  logic [SCR_W-1:0]     bcd_q;

  logic [SCR_W-1:0]     scratch_adj;
  logic [SCR_W-1:0]     scratch_d;
  logic [SCR_W-1:0]     bcd_load;
  logic                 accept;
  logic                 last_shift;
  logic                 unused_top_bit;

  // ---------------------------------------------------------------------------
  // Per-digit add-3 correction ahead of the shift
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3_cell u_cell (
      .digit_i (scratch_q[4*g +: 4]),
      .digit_o (scratch_adj[4*g +: 4])
    );
  end

  // The bit shifted out of the top digit is always zero while DIGITS is legal.
  assign unused_top_bit = scratch_adj[SCR_W-1];
  assign scratch_d      = {scratch_adj[SCR_W-2:0], bin_q[BIN_WIDTH-1]};

  assign accept     = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign last_shift = (state_q == ST_SHIFT) && (cnt_q == CNT_W'(BIN_WIDTH - 1));

  // ---------------------------------------------------------------------------
  // Value loaded into bcd_out on the final shift edge
  // ---------------------------------------------------------------------------
  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so the running 'lead' flag works and no latch is inferred.
  always_comb begin
    bcd_load = scratch_d;
`ifdef BCD_LEADING_BLANK_EN
    begin : blank_leading
      logic lead;
      lead = 1'b1;
      // Walk down from the top digit; digit 0 is never blanked so zero shows "0".
      for (int i = DIGITS - 1; i >= 1; i--) begin
        if (lead && scratch_d[4*i +: 4] == 4'd0) begin
          bcd_load[4*i +: 4] = BCD_BLANK;
        end else begin
          lead = 1'b0;
        end
      end
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking '<=' so every register samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_SHIFT;
      ST_SHIFT: if (last_shift) state_d = ST_DONE;
      ST_DONE:  state_d = start ? ST_SHIFT : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy    = (state_q == ST_SHIFT);
    done    = (state_q == ST_DONE);
    bcd_out = bcd_q;
  end

  // ---------------------------------------------------------------------------
  // Datapath: shift register, scratch digits, bit counter, result
  // ---------------------------------------------------------------------------
  // NOTE: every datapath register is reset, so an aborted conversion leaves
  // no stale partial result visible after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
    end else if (accept) begin
      bin_q     <= bin_in;
      scratch_q <= '0;
      cnt_q     <= '0;
    end else if (state_q == ST_SHIFT) begin
      bin_q     <= bin_q << 1;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_q + CNT_W'(1);
      if (last_shift) begin
        bcd_q <= bcd_load;
      end
    end
  end

endmodule : bin_to_bcd_encoder

// File: tb/tb_bin_to_bcd_encoder.sv
module tb_bin_to_bcd_encoder;

  localparam int W = 16;
  localparam int D = 5;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   bin_in = '0;
  logic           busy;
  logic           done;
  logic [4*D-1:0] bcd_out;

  int n_cmp = 0;
  int n_err = 0;

  bin_to_bcd_encoder #(.BIN_WIDTH(W), .DIGITS(D)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out)
  );

  always #5 clk = ~clk;

  // Reference: decimal digits by division, then optional leading blanking.
  function automatic logic [4*D-1:0] ref_bcd(input int unsigned v);
    logic [4*D-1:0] r;
    int unsigned    x;
    r = '0;
    x = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
`ifdef BCD_LEADING_BLANK_EN
    for (int i = D - 1; i >= 1; i--) begin
      if (v < 10 ** i) r[4*i +: 4] = 4'hF;
    end
`endif
    return r;
  endfunction

  // Inputs are driven and outputs sampled 1 ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for done (bounded); lat counts edges after the current point.
  task automatic wait_done(output int lat, output bit seen, input bit jitter);
    lat  = 0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      lat++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (jitter) begin
        bin_in = W'($urandom);
        start  = 1'($urandom);
      end
    end
  endtask

  // Issue one start pulse and wait for the result.
  task automatic convert(input logic [W-1:0] v, output int lat, output bit seen);
    bin_in = v;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    wait_done(lat, seen, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_cmp++;
    if ({busy, done, bcd_out} !== {2'b00, 20'h00000}) begin
      n_err++;
      $display("FAIL reset_state: busy=%b done=%b bcd=%h, want 0 0 00000", busy, done, bcd_out);
    end
    tick();
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_err++;
      $display("FAIL idle_after_reset: busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] vals [3] = '{16'd1234, 16'd65535, 16'd0};
    int lat;
    bit seen;
    foreach (vals[i]) begin
      bin_in = vals[i];
      start  = 1'b1;
      tick();
      start  = 1'b0;
      n_cmp++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_err++;
        $display("FAIL busy_rise_%0d: busy=%b done=%b, want 1 0", vals[i], busy, done);
      end
      wait_done(lat, seen, 1'b0);
      n_cmp++;
      if (!seen || lat != W) begin
        n_err++;
        $display("FAIL latency_%0d: seen=%0b lat=%0d, want %0d", vals[i], seen, lat, W);
      end
      n_cmp++;
      if (bcd_out !== ref_bcd(vals[i]) || busy !== 1'b0) begin
        n_err++;
        $display("FAIL result_%0d: bcd=%h busy=%b, want %h busy=0", vals[i], bcd_out, busy, ref_bcd(vals[i]));
      end
      tick();
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0 || bcd_out !== ref_bcd(vals[i])) begin
        n_err++;
        $display("FAIL done_fall_%0d: done=%b busy=%b bcd=%h", vals[i], done, busy, bcd_out);
      end
    end
  endtask

  task automatic test_random();
    int lat;
    bit seen;
    logic [W-1:0] v;
    for (int i = 0; i < 20; i++) begin
      v = W'($urandom);
      convert(v, lat, seen);
      n_cmp++;
      if (!seen || lat != W || bcd_out !== ref_bcd(v)) begin
        n_err++;
        $display("FAIL random_%0d: seen=%0b lat=%0d bcd=%h, want lat=%0d bcd=%h", v, seen, lat, bcd_out, W, ref_bcd(v));
      end
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) tick();
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    bit seen;
    bin_in = 16'd9;
    start  = 1'b1;
    tick();
    // start stays high and bin_in wanders while shifting; both must be ignored.
    wait_done(lat, seen, 1'b1);
    n_cmp++;
    if (!seen || lat != W || bcd_out !== ref_bcd(9)) begin
      n_err++;
      $display("FAIL b2b_first: seen=%0b lat=%0d bcd=%h, want lat=%0d bcd=%h", seen, lat, bcd_out, W, ref_bcd(9));
    end
    bin_in = 16'd10;
    start  = 1'b1;
    tick();
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_restart_busy: busy=%b done=%b, want 1 0", busy, done);
    end
    wait_done(lat, seen, 1'b1);
    n_cmp++;
    if (!seen || lat + 1 != W + 1 || bcd_out !== ref_bcd(10)) begin
      n_err++;
      $display("FAIL b2b_second: seen=%0b spacing=%0d bcd=%h, want spacing=%0d bcd=%h", seen, lat + 1, bcd_out, W + 1, ref_bcd(10));
    end
    start = 1'b0;
    tick();
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_idle: done=%b busy=%b, want 0 0", done, busy);
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    bit seen;
    bit saw_done = 1'b0;
    bin_in = 16'd4321;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, bcd_out} !== {2'b00, 20'h00000}) begin
      n_err++;
      $display("FAIL abort_async: busy=%b done=%b bcd=%h, want 0 0 00000", busy, done, bcd_out);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (done || busy) saw_done = 1'b1;
    end
    n_cmp++;
    if (saw_done || bcd_out !== 20'h00000) begin
      n_err++;
      $display("FAIL abort_quiet: activity=%0b bcd=%h, want 0 00000", saw_done, bcd_out);
    end
    convert(16'd999, lat, seen);
    n_cmp++;
    if (!seen || lat != W || bcd_out !== ref_bcd(999)) begin
      n_err++;
      $display("FAIL after_abort_999: seen=%0b lat=%0d bcd=%h, want %h", seen, lat, bcd_out, ref_bcd(999));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_bin_to_bcd_encoder

// File: doc/bin_to_bcd_encoder.md
# bin_to_bcd_encoder

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm. It accepts an unsigned binary value and produces packed BCD digits. Those digits feed the banner's per-digit BCD-to-seven-segment decoders. One conversion is in flight at a time, with a start/done handshake; one bit is processed per clock.

## Interface
- BIN_WIDTH, default 16: width of the unsigned binary input.
- DIGITS, default 5: number of BCD output digits. Must satisfy DIGITS ≥ ceil(BIN_WIDTH·log10(2)); a violation is a simulation-time fatal error.
- clk  input  1: single clock; all state is updated on the rising edge.
- rst_n  input  1: reset, asynchronous assert, active-low.
- start  input  1: request a conversion; sampled only in IDLE or DONE.
- bin_in  input  BIN_WIDTH: value to convert; captured on the accepting edge only.
- busy  output  1: high while the conversion is in progress (SHIFT state).
- done  output  1: one-cycle pulse; bcd_out is valid and newly updated.
- bcd_out  output  4·DIGITS: packed BCD result, digit 0 in bits [3:0]; held until the next done.

## Operation
- FSM states and transitions:
  - IDLE: start=1 → SHIFT.
  - SHIFT: exits when the last shift is done → DONE.
  - DONE: start=1 → SHIFT; otherwise → IDLE.
- On acceptance:
  - Latch bin_in into the shift register.
  - Clear the 4·DIGITS scratch register.
  - Clear the bit counter (width clog2(BIN_WIDTH+1)).
- Each SHIFT cycle:
  - Every scratch digit ≥ 5 gets +3 (4-bit, no carry out).
  - Then {scratch, bin} shifts left by 1; the MSB of bin enters scratch bit 0.
  - The counter increments.
- After BIN_WIDTH shifts, the final scratch value is written into bcd_out on the same edge, and the state moves to DONE.
- start while busy=1 is ignored; bin_in changes during SHIFT have no effect.
- DONE: done=1 and busy=0 for exactly one cycle. start in this cycle is accepted, so back-to-back throughput is BIN_WIDTH+1 cycles per conversion.
- The scratch register never overflows when the DIGITS constraint holds; the top digit cannot exceed 9.

## Timing
- Reset values: busy=0, done=0, bcd_out=0, state=IDLE, counter=0, scratch=0.
- start sampled high at edge E0:
  - busy rises after E0.
  - Shifts occur at edges E1..E_BIN_WIDTH.
  - bcd_out updates and done rises after E_BIN_WIDTH.
  - done and busy fall after E_BIN_WIDTH+1 unless restarted (restart keeps busy high).
- Latency from the start-sampling edge to done visible is BIN_WIDTH cycles.
- Reset asserted mid-conversion:
  - Immediate abort; all outputs return to reset values asynchronously.
  - No done is produced.
  - After deassertion the block waits in IDLE.
- Reset deassertion is synchronized externally; the block assumes deassertion is clean relative to clk.

## Configuration
- BCD_LEADING_BLANK_EN:
  - Defined: when bcd_out is loaded, every leading zero digit above digit 0 is replaced by the blank code 4'hF. The downstream segment decoder renders 4'hF as all-off. Digit 0 always shows its value, so zero displays as a single "0". Latency is unchanged.
  - Undefined: bcd_out carries plain BCD with leading zeros.

## Structure
- Package bcd_pkg holds:
  - the FSM state encoding (IDLE, SHIFT, DONE);
  - the localparam BCD_BLANK = 4'hF;
  - the digit-count check function used for the DIGITS assertion.
- Sub-module bcd_add3_cell: combinational 4-bit "if ≥5 add 3" correction, instantiated DIGITS times by generate loop.
- Leading-blank logic lives inline, guarded by the macro.

## Test plan
- Reset with rst_n=0 mid-idle → busy=0, done=0, bcd_out=20'h00000.
- bin_in=16'd1234, start pulse → done exactly 16 cycles after the sampling edge; bcd_out=20'h01234 (20'hF1234 with BCD_LEADING_BLANK_EN).
- bin_in=16'd65535 → bcd_out=20'h65535; bin_in=0 → 20'h00000 (20'hFFFF0 with macro).
- start held with bin_in=9, then start reasserted in the DONE cycle with bin_in=10:
  - results 20'h00009 then 20'h00010, 17 cycles apart;
  - start pulses during busy are ignored;
  - bin_in toggling during SHIFT does not alter the result.
- bin_in=16'd4321, rst_n pulsed low 5 cycles after start → no done; outputs zero. A following conversion of 16'd999 yields 20'h00999.
